// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 receive path.
// Holds the receiver state encoding, frame/byte geometry, a parity helper
// and the scan-code constants consumed by the downstream decoder.
package ps2_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned FRAME_LEN = 11;   // start + 8 data + parity + stop
    localparam int unsigned BIT_CNT_W = 3;    // indexes the 8 data bits

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // Scan-code set 2 constants used by the decoder
    localparam logic [BYTE_W-1:0] SC_EXTEND = 8'hE0;
    localparam logic [BYTE_W-1:0] SC_BREAK  = 8'hF0;
    localparam logic [BYTE_W-1:0] SC_A      = 8'h1C;
    localparam logic [BYTE_W-1:0] SC_ENTER  = 8'h5A;
    localparam logic [BYTE_W-1:0] SC_KP4    = 8'h6B;
    localparam logic [BYTE_W-1:0] SC_KP8    = 8'h75;
    localparam logic [BYTE_W-1:0] SC_SPACE  = 8'h29;

    // Odd parity over data + parity bit: true when the count of ones is odd
    function automatic logic parity_ok(input logic [BYTE_W-1:0] data, input logic par);
        return ^{par, data};
    endfunction

endpackage

// File: rtl/ps2_rx_if.sv
// ps2_rx_if: bundles the PS/2 line pair and the received-byte strobes.
//   ps2_clk/ps2_data : raw PS/2 lines (host side drives them)
//   rx_data/rx_valid : received byte and its one-cycle strobe
//   rx_err/busy      : frame error strobe and frame-in-progress flag
interface ps2_rx_if;
    import ps2_pkg::*;

    logic              ps2_clk;
    logic              ps2_data;
    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_err;
    logic              busy;

    // Line driver / byte consumer side
    modport master (
        output ps2_clk, ps2_data,
        input  rx_data, rx_valid, rx_err, busy
    );

    // Receiver side
    modport slave (
        input  ps2_clk, ps2_data,
        output rx_data, rx_valid, rx_err, busy
    );

endinterface

// File: rtl/ps2_sync_filter.sv
// ps2_sync_filter: 2-flop synchronizer followed by a glitch filter.
//   clk, rst : system clock, synchronous active-high reset
//   din      : raw asynchronous input
//   dout     : filtered level; changes only after FILTER_LEN consecutive
//              synchronized samples disagree with the current output
module ps2_sync_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

    logic             meta_q;
    logic             sync_q;
    logic             filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Synchronizer and filter state; lines idle high
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    // Any sample matching the current output restarts the run count
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q != filt_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                filt_d = sync_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign dout = filt_q;

endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host frame receiver.
//   clk, rst          : system clock, synchronous active-high reset
//   ps2_clk, ps2_data : raw PS/2 lines, asynchronous to clk
//   rx_data           : last good byte, held until the next good frame
//   rx_valid          : one-cycle strobe, rx_data is new
//   rx_err            : one-cycle strobe on parity/stop/timeout failure
//   busy              : frame in progress
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 10000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_err,
    output logic              busy
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

    logic                 clk_filt;
    logic                 clk_prev_q;
    logic                 data_meta_q, data_sync_q;
    logic                 fall_c;

    ps2_state_e           state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]    shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [BYTE_W-1:0]    rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_err_q, rx_err_d;
    logic                 busy_q, busy_d;

    // Clock line: synchronize and deglitch
    ps2_sync_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filt (
        .clk  (clk),
        .rst  (rst),
        .din  (ps2_clk),
        .dout (clk_filt)
    );

    // Data line: plain 2-flop synchronizer; edge detect history for the clock
    always_ff @(posedge clk) begin
        if (rst) begin
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            clk_prev_q  <= 1'b1;
        end else begin
            data_meta_q <= ps2_data;
            data_sync_q <= data_meta_q;
            clk_prev_q  <= clk_filt;
        end
    end

    assign fall_c = clk_prev_q & ~clk_filt;

    // Frame state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tmo_q      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tmo_q      <= tmo_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state, datapath and strobe generation
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        tmo_d      = tmo_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;

        // Inter-edge watchdog: idle or edge clears, otherwise count and saturate
        if (state_q == ST_IDLE || fall_c) begin
            tmo_d = '0;
        end else if (tmo_q != TMO_MAX) begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        if (state_q != ST_IDLE && tmo_q == TMO_MAX) begin
            // Stalled frame: drop the partial byte and report it
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            shift_d   = '0;
            rx_err_d  = 1'b1;
        end else if (fall_c) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!data_sync_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    // LSB arrives first, so shift in from the top
                    shift_d   = {data_sync_q, shift_q[BYTE_W-1:1]};
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1)) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_d = data_sync_q;
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    if (data_sync_q && parity_ok(shift_q, parity_q)) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_err   = rx_err_q;
    assign busy     = busy_q;

endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive equal synchronized samples required before the filtered ps2_clk may change.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 10000: maximum clk cycles allowed between falling edges inside a frame (200 us at 50 MHz).
REQ-003 SHALL have port clk  input  1  system clock; the only clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
REQ-007 SHALL have port rx_data  output  8  last correctly received byte; held until the next valid frame.
REQ-008 SHALL have port rx_valid  output  1  one-cycle strobe; rx_data is new this cycle.
REQ-009 SHALL have port rx_err  output  1  one-cycle strobe on parity, stop-bit or timeout failure.
REQ-010 SHALL have port busy  output  1  high while a frame is in progress (state != IDLE).

Function
REQ-011 SHALL pass ps2_clk and ps2_data through two flip-flops each before any use.
REQ-012 SHALL glitch-filter synchronized ps2_clk: filtered value updates only after FILTER_LEN consecutive equal samples.
REQ-013 SHALL detect a falling edge as filtered ps2_clk going 1->0 and sample synchronized ps2_data in that same cycle.
REQ-014 SHALL implement states IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: falling edge with data=0 -> DATA with bit count 0; falling edge with data=1 -> stay IDLE, no strobe.
REQ-016 DATA: each falling edge shifts one bit into the LSB-first shift register; after the 8th bit -> PARITY.
REQ-017 PARITY: falling edge stores the parity bit -> STOP.
REQ-018 STOP: falling edge -> IDLE; frame is good iff stop bit=1 and the 9 bits (data+parity) contain an odd number of ones.
REQ-019 Good frame: rx_data and rx_valid=1 SHALL update in the cycle after the stop-bit edge; rx_valid SHALL be high exactly one cycle.
REQ-020 Bad frame: rx_err=1 for one cycle after the stop-bit edge; rx_data unchanged; rx_valid stays 0.
REQ-021 Timeout counter SHALL clear on every falling edge and in IDLE, count otherwise, and saturate.
REQ-022 Counter reaching TIMEOUT_CYCLES in DATA/PARITY/STOP -> IDLE next cycle, rx_err one-cycle pulse, partial byte discarded.
REQ-023 rx_valid and rx_err SHALL never be high in the same cycle.
REQ-024 Minimum throughput: back-to-back frames with no idle gap beyond one PS/2 bit period SHALL all be received.

Reset
REQ-025 On rst: state=IDLE, rx_data=0x00, rx_valid=0, rx_err=0, busy=0, bit count=0, timeout counter=0.
REQ-026 On rst: synchronizer and filtered clock flops = 1 (idle line level), filter counter = 0.
REQ-027 rst mid-frame SHALL abort the frame with no rx_valid and no rx_err strobe.

Structure
REQ-028 State encodings, frame length (11) and the byte width (8) SHALL live in shared package ps2_pkg, also home of the scan-code constants used by the decoder.
REQ-029 Synchronizer plus glitch filter SHALL be sub-module ps2_sync_filter, instantiated for ps2_clk; ps2_data SHALL use only its 2-flop synchronizer.
REQ-030 rx_data/rx_valid SHALL connect directly to the downstream scan-code decoder.

Verification (FILTER_LEN=8, TIMEOUT_CYCLES=10000, PS/2 bit period 4000 clk)
REQ-031 Frame 0x5A (start 0, bits 0,1,0,1,1,0,1,0, parity 1, stop 1) -> one rx_valid pulse, rx_data=0x5A, rx_err=0.
REQ-032 Frames 0xF0 (parity 1) then 0x6B (parity 0), back-to-back -> two rx_valid pulses, rx_data 0xF0 then 0x6B.
REQ-033 Frame 0x5A with parity 0 -> rx_err one pulse, no rx_valid, rx_data keeps its previous value.
REQ-034 Start plus 5 data bits, then line idle -> rx_err pulse ~10000 cycles after last edge, busy=0; next frame 0x75 (parity 0) -> rx_valid, rx_data=0x75.
REQ-035 3-cycle low glitch on ps2_clk while idle -> busy stays 0, no strobe.
REQ-036 rst pulse after 4 data bits, then full frame 0x29 (parity 0) -> exactly one rx_valid, rx_data=0x29, no rx_err.
